// File: rtl/aes_pkg.sv
// Shared types and constants for the AES CTR streaming front end.
package aes_pkg;

   typedef logic [127:0] aes_block_t;

   localparam int AES_CORE_LAT = 11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_ERR
   } ctr_state_e;

endpackage

// File: rtl/aes_ctr_stream_if.sv
// Bundle of the IV, plaintext, result and AES core handshakes seen by aes_ctr_stream.
interface aes_ctr_stream_if #(
   parameter int DATA_W = 128
);
   logic              iv_load;
   logic [DATA_W-1:0] iv_in;
   logic              pt_valid;
   logic              pt_ready;
   logic [DATA_W-1:0] pt_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              core_valid;
   logic              core_ready;
   logic [DATA_W-1:0] core_data;
   logic              core_keys_vld;
   logic              core_out_vld;
   logic [DATA_W-1:0] core_out_data;
   logic              busy;
   logic              ctr_err;

   modport slave (
      input  iv_load, iv_in, pt_valid, pt_data, out_ready,
             core_ready, core_keys_vld, core_out_vld, core_out_data,
      output pt_ready, out_valid, out_data, core_valid, core_data, busy, ctr_err
   );

   modport master (
      output iv_load, iv_in, pt_valid, pt_data, out_ready,
             core_ready, core_keys_vld, core_out_vld, core_out_data,
      input  pt_ready, out_valid, out_data, core_valid, core_data, busy, ctr_err
   );
endinterface

// File: rtl/aes_sync_fifo.sv
// Show-ahead synchronous FIFO: rdata is the head entry whenever empty is low.
module aes_sync_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/aes_ctr_stream.sv
// CTR-mode front end for the pipelined AES encrypt core: issues counter blocks, XORs keystream on return.
// Optional macro AES_CTR_WRAP_ERR_EN: stop with ctr_err instead of silently wrapping the counter.
//
//   state   | meaning
//   S_IDLE  | no IV loaded yet, nothing accepted
//   S_RUN   | accepting plaintext, counter advancing
//   S_DRAIN | new IV pending, waiting for all outstanding blocks to leave
//   S_ERR   | counter exhausted, only draining (macro builds only)
module aes_ctr_stream
   import aes_pkg::*;
#(
   parameter int DATA_W    = 128,
   parameter int CTR_W     = 32,
   parameter int OUT_DEPTH = 16
) (
   input logic             clk,
   input logic             rst,
   aes_ctr_stream_if.slave bus
);
   localparam int CRW = $clog2(OUT_DEPTH + 1);
   localparam int QW  = $clog2(AES_CORE_LAT + 1);

   ctr_state_e        state;
   logic [DATA_W-1:0] ctr;
   logic [DATA_W-1:0] ctr_next;
   logic [DATA_W-1:0] pend_iv;
   logic [DATA_W-1:0] pt_head;
   logic [DATA_W-1:0] out_head;
   logic [CRW-1:0]    credits;
   logic [CRW-1:0]    pt_count;
   logic [CRW-1:0]    out_count;
   logic [QW-1:0]     quiet;
   logic              accept;
   logic              ks_ret;
   logic              ret;
   logic              busy_i;
   logic              pt_empty;
   logic              pt_full;
   logic              out_empty;
   logic              out_full;

   assign busy_i       = (credits != CRW'(OUT_DEPTH));
   assign bus.pt_ready = (state == S_RUN) & bus.core_ready & bus.core_keys_vld & (credits != '0);
   assign accept       = bus.pt_valid & bus.pt_ready;
   assign bus.core_valid = accept;
   assign bus.core_data  = ctr;
   assign ks_ret       = bus.core_out_vld & ~pt_empty;
   assign bus.out_valid = ~out_empty;
   assign bus.out_data  = out_empty ? '0 : out_head;
   assign ret          = ~out_empty & bus.out_ready;
   assign bus.busy     = busy_i;
   assign ctr_next     = {ctr[DATA_W-1:CTR_W], ctr[CTR_W-1:0] + CTR_W'(1)};

`ifdef AES_CTR_WRAP_ERR_EN
   assign bus.ctr_err = (state == S_ERR);
`else
   assign bus.ctr_err = 1'b0;
`endif

   aes_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_pt_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (ks_ret),
      .wdata (bus.pt_data),
      .rdata (pt_head),
      .full  (pt_full),
      .empty (pt_empty),
      .count (pt_count)
   );

   aes_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ks_ret),
      .pop   (ret),
      .wdata (pt_head ^ bus.core_out_data),
      .rdata (out_head),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         credits <= CRW'(OUT_DEPTH);
      else if (accept & ~ret)
         credits <= credits - CRW'(1);
      else if (ret & ~accept)
         credits <= credits + CRW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         ctr     <= '0;
         pend_iv <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.iv_load) begin
                  ctr   <= bus.iv_in;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (bus.iv_load) begin
                  if (busy_i) begin
                     pend_iv <= bus.iv_in;
                     state   <= S_DRAIN;
                  end else begin
                     ctr <= bus.iv_in;
                  end
               end else if (accept) begin
                  ctr <= ctr_next;
`ifdef AES_CTR_WRAP_ERR_EN
                  if (&ctr[CTR_W-1:0])
                     state <= S_ERR;
`endif
               end
            end
            S_DRAIN: begin
               // the newest IV wins if one arrives on the cycle the drain completes
               if (!busy_i) begin
                  ctr   <= bus.iv_load ? bus.iv_in : pend_iv;
                  state <= S_RUN;
               end else if (bus.iv_load) begin
                  pend_iv <= bus.iv_in;
               end
            end
`ifdef AES_CTR_WRAP_ERR_EN
            S_ERR: begin
               if (bus.iv_load) begin
                  if (busy_i) begin
                     pend_iv <= bus.iv_in;
                     state   <= S_DRAIN;
                  end else begin
                     ctr   <= bus.iv_in;
                     state <= S_RUN;
                  end
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

   // Core results issued before a reset may still emerge for one core latency afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         quiet <= QW'(AES_CORE_LAT);
      else if (quiet != '0)
         quiet <= quiet - QW'(1);
   end

   a_no_orphan_result: assert property (@(posedge clk) disable iff (rst)
      (bus.core_out_vld && quiet == '0) |-> !pt_empty);
   a_no_pt_overflow: assert property (@(posedge clk) disable iff (rst) !(accept && pt_full));
   a_no_out_overflow: assert property (@(posedge clk) disable iff (rst) !(ks_ret && out_full));
   a_credit_balance: assert property (@(posedge clk) disable iff (rst)
      int'(pt_count) + int'(out_count) + int'(credits) == OUT_DEPTH);
endmodule

// File: tb/tb_aes_ctr_stream.sv
// Scoreboard bench for aes_ctr_stream with a fixed-latency behavioural AES core stand-in.
module tb_aes_ctr_stream;
   import aes_pkg::*;

   localparam aes_block_t NIST_IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam aes_block_t NIST_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam aes_block_t NIST_CT  = 128'h874d6191b620e3261bef6864990db6ce;
   localparam aes_block_t NIST_C2  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
   localparam aes_block_t IV4      = 128'hdeadbeef_01234567_89abcdef_00000040;
   localparam aes_block_t IV5      = 128'h00112233_44556677_8899aabb_ffffffff;
   localparam aes_block_t IV5_NEXT = 128'h00112233_44556677_8899aabb_00000000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes_ctr_stream_if bus ();

   aes_ctr_stream dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   aes_block_t q[$];
   aes_block_t exp_ctr;

   // Stand-in keystream: the NIST F.5.1 block-1 value for its counter, a fixed scramble otherwise.
   function automatic aes_block_t ks(input aes_block_t x);
      if (x == NIST_IV)
         return 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
      return {x[63:0], x[127:64]} ^ 128'h5a5ac3c30f0f9696a5a53c3cf0f06969;
   endfunction

   logic [AES_CORE_LAT-1:0] pv = '0;
   aes_block_t              pd [AES_CORE_LAT];
   always @(posedge clk) begin
      pv    <= {pv[AES_CORE_LAT-2:0], bus.core_valid};
      pd[0] <= ks(bus.core_data);
      for (int i = 1; i < AES_CORE_LAT; i++)
         pd[i] <= pd[i-1];
   end
   assign bus.core_out_vld  = pv[AES_CORE_LAT-1];
   assign bus.core_out_data = pd[AES_CORE_LAT-1];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always begin
      @(negedge clk);
      #4;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_out: got %h with nothing expected", bus.out_data);
         end else begin
            chk("out_data", bus.out_data, q.pop_front());
         end
      end
   end

   task automatic send(input aes_block_t d, input bit use_exp, input aes_block_t exp_out,
                       output int waited);
      waited = 0;
      bus.pt_valid = 1'b1;
      bus.pt_data  = d;
      #1;
      while (!bus.pt_ready && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (bus.pt_ready) begin
         chk("core_valid", bus.core_valid, 1);
         chk("core_data", bus.core_data, exp_ctr);
         q.push_back(use_exp ? exp_out : (d ^ ks(exp_ctr)));
         exp_ctr[31:0] = exp_ctr[31:0] + 32'd1;
      end else begin
         chk("send_timeout", bus.pt_ready, 1);
      end
      @(negedge clk);
      bus.pt_valid = 1'b0;
   endtask

   task automatic load_iv(input aes_block_t v);
      bus.iv_in   = v;
      bus.iv_load = 1'b1;
      @(negedge clk);
      bus.iv_load = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      #1;
      while (bus.busy && t < 200) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk(name, bus.busy, 0);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int w, stalls, acc, cnt, viol, ov;
      logic first_ready;
      bus.iv_load       = 1'b0;
      bus.iv_in         = '0;
      bus.pt_valid      = 1'b1;
      bus.pt_data       = '0;
      bus.out_ready     = 1'b1;
      bus.core_ready    = 1'b1;
      bus.core_keys_vld = 1'b1;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_pt_ready", bus.pt_ready, 0);
      chk("rst_core_valid", bus.core_valid, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ctr_err", bus.ctr_err, 0);
      chk("rst_core_data", bus.core_data, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_pt_ready", bus.pt_ready, 0);
      bus.pt_valid = 1'b0;
      @(negedge clk);

      // NIST SP800-38A F.5.1 first block, then the incremented counter
      load_iv(NIST_IV);
      exp_ctr = NIST_IV;
      bus.core_keys_vld = 1'b0;
      #1;
      chk("nokeys_pt_ready", bus.pt_ready, 0);
      bus.core_keys_vld = 1'b1;
      #1;
      chk("run_pt_ready", bus.pt_ready, 1);
      @(negedge clk);
      send(NIST_PT, 1'b1, NIST_CT, w);
      #1;
      chk("nist_ctr2", bus.core_data, NIST_C2);
      send(128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b0, '0, w);
      wait_idle("nist_idle");

      // 64-block stream at full rate
      stalls = 0;
      for (int i = 0; i < 64; i++) begin
         send({32'(i), 32'h5eed0000 + 32'(i), ~32'(i), 32'hc0ffee00 ^ 32'(i)}, 1'b0, '0, w);
         stalls += w;
      end
      chk("stream_stalls", stalls, 0);
      wait_idle("stream_idle");
      chk("stream_queue_empty", q.size(), 0);

      // Output backpressure: credits cap outstanding blocks at OUT_DEPTH
      bus.out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 40; c++) begin
         bus.pt_valid = 1'b1;
         bus.pt_data  = {96'h1111_2222_3333_4444_5555_6666, 32'(c)};
         #1;
         if (bus.pt_ready) begin
            chk("bp_core_data", bus.core_data, exp_ctr);
            q.push_back(bus.pt_data ^ ks(exp_ctr));
            exp_ctr[31:0] = exp_ctr[31:0] + 32'd1;
            acc++;
         end
         @(negedge clk);
      end
      bus.pt_valid = 1'b0;
      #1;
      chk("bp_accepts", acc, 16);
      chk("bp_pt_ready", bus.pt_ready, 0);
      chk("bp_busy", bus.busy, 1);
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_pt_ready", bus.pt_ready, 0);
      cnt = 0;
      first_ready = 1'b0;
      while (bus.busy && cnt < 100) begin
         @(negedge clk);
         #1;
         cnt++;
         if (cnt == 1)
            first_ready = bus.pt_ready;
      end
      chk("bp_first_credit", first_ready, 1);
      chk("bp_credit_return_cycles", cnt, 16);
      @(negedge clk);

      // IV reload with 5 blocks outstanding
      for (int i = 0; i < 5; i++)
         send(128'h0badf00d_00000000_00000000_00000000 + 128'(i), 1'b0, '0, w);
      load_iv(IV4);
      #1;
      chk("drain_busy", bus.busy, 1);
      viol = 0;
      cnt = 0;
      while (bus.busy && cnt < 100) begin
         if (bus.pt_ready)
            viol++;
         @(negedge clk);
         #1;
         cnt++;
      end
      chk("drain_pt_ready_low", viol, 0);
      chk("drain_done", bus.busy, 0);
      @(negedge clk);
      #1;
      chk("reload_core_data", bus.core_data, IV4);
      exp_ctr = IV4;
      send(128'h13579bdf_2468ace0_fedcba98_76543210, 1'b0, '0, w);
      wait_idle("reload_idle");

      // Counter low field at all ones wraps silently
      load_iv(IV5);
      exp_ctr = IV5;
      send(128'h00000000_11111111_22222222_33333333, 1'b0, '0, w);
      #1;
      chk("wrap_core_data", bus.core_data, IV5_NEXT);
      chk("wrap_ctr_err", bus.ctr_err, 0);
      chk("wrap_pt_ready", bus.pt_ready, 1);
      @(negedge clk);
      send(128'h44444444_55555555_66666666_77777777, 1'b0, '0, w);
      wait_idle("wrap_idle");

      // Reset mid-stream with results both buffered and still inside the core
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         send(128'h99990000_00000000_00000000_00000000 + 128'(i), 1'b0, '0, w);
      repeat (14) @(negedge clk);
      for (int i = 0; i < 3; i++)
         send(128'h88880000_00000000_00000000_00000000 + 128'(i), 1'b0, '0, w);
      repeat (2) @(negedge clk);
      #1;
      chk("pre_rst_out_valid", bus.out_valid, 1);
      bus.pt_valid = 1'b1;
      rst = 1'b1;
      #1;
      q.delete();
      chk("mid_rst_pt_ready", bus.pt_ready, 0);
      chk("mid_rst_core_valid", bus.core_valid, 0);
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_out_data", bus.out_data, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_ctr_err", bus.ctr_err, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.pt_valid  = 1'b0;
      bus.out_ready = 1'b1;
      ov = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (bus.out_valid)
            ov++;
         @(negedge clk);
      end
      chk("late_out_valid", ov, 0);
      chk("post_rst_pt_ready", bus.pt_ready, 0);

      load_iv(NIST_IV);
      exp_ctr = NIST_IV;
      send(NIST_PT, 1'b1, NIST_CT, w);
      wait_idle("recover_idle");
      chk("final_queue_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
